// File: rtl/cordic_arbiter.sv
// Two-requester credit-gated arbiter feeding a non-stallable CORDIC pipeline.
// Define CORDIC_ARB_FIXED_PRIO_EN for fixed priority (req0 wins), else round-robin.
module cordic_arbiter #(
    parameter int W     = 32,
    parameter int LAT   = 16,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_mode,
    input  logic [W-1:0] req0_x,
    input  logic [W-1:0] req0_y,
    input  logic [W-1:0] req0_z,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_mode,
    input  logic [W-1:0] req1_x,
    input  logic [W-1:0] req1_y,
    input  logic [W-1:0] req1_z,
    output logic         cd_mode,
    output logic [W-1:0] cd_x,
    output logic [W-1:0] cd_y,
    output logic [W-1:0] cd_z,
    input  logic [W-1:0] cd_xo,
    input  logic [W-1:0] cd_yo,
    input  logic [W-1:0] cd_zo,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_x,
    output logic [W-1:0] rsp_y,
    output logic [W-1:0] rsp_z,
    output logic         busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = 3 * W + 1;

    logic [CW-1:0] credits_q, credits_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [LAT:0]  sv_q, sv_d;
    logic [LAT:0]  sid_q, sid_d;
    logic          cd_mode_q, cd_mode_d;
    logic [W-1:0]  cd_x_q, cd_x_d;
    logic [W-1:0]  cd_y_q, cd_y_d;
    logic [W-1:0]  cd_z_q, cd_z_d;
    logic [FW-1:0] mem_q [DEPTH];
    logic [FW-1:0] wdata;
    logic [FW-1:0] head;
    logic          grant;
    logic          has_credit;
    logic          acc;
    logic          pop;
    logic          cap;

`ifdef CORDIC_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = req1_valid && !req0_valid;
    end
`else
    logic lg_q, lg_d;

    // Under contention, the requester not granted last time wins.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~lg_q;
        end
        lg_d = acc ? grant : lg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lg_q <= 1'b1;
        end else begin
            lg_q <= lg_d;
        end
    end
`endif

    always_comb begin
        has_credit = (credits_q != '0) && !rst;
        req0_ready = has_credit && !grant;
        req1_ready = has_credit && grant;
        acc        = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        rsp_valid  = (cnt_q != '0);
        pop        = rsp_valid && rsp_ready;
        cap        = sv_q[LAT];
        wdata      = {sid_q[LAT], cd_xo, cd_yo, cd_zo};
        head       = mem_q[rp_q];
        rsp_id     = rsp_valid && head[FW-1];
        rsp_x      = rsp_valid ? head[3*W-1:2*W] : '0;
        rsp_y      = rsp_valid ? head[2*W-1:W] : '0;
        rsp_z      = rsp_valid ? head[W-1:0] : '0;
        busy       = (|sv_q) || (cnt_q != '0);
    end

    always_comb begin
        credits_d = credits_q;
        if (acc && !pop) begin
            credits_d = credits_q - CW'(1);
        end else if (!acc && pop) begin
            credits_d = credits_q + CW'(1);
        end
        cnt_d = cnt_q + CW'(cap) - CW'(pop);
        wp_d  = cap ? wp_q + AW'(1) : wp_q;
        rp_d  = pop ? rp_q + AW'(1) : rp_q;
        sv_d  = {sv_q[LAT-1:0], acc};
        sid_d = {sid_q[LAT-1:0], grant & acc};
    end

    always_comb begin
        cd_mode_d = cd_mode_q;
        cd_x_d    = cd_x_q;
        cd_y_d    = cd_y_q;
        cd_z_d    = cd_z_q;
        if (acc) begin
            cd_mode_d = grant ? req1_mode : req0_mode;
            cd_x_d    = grant ? req1_x : req0_x;
            cd_y_d    = grant ? req1_y : req0_y;
            cd_z_d    = grant ? req1_z : req0_z;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= CW'(DEPTH);
            cnt_q     <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            sv_q      <= '0;
            sid_q     <= '0;
            cd_mode_q <= 1'b0;
            cd_x_q    <= '0;
            cd_y_q    <= '0;
            cd_z_q    <= '0;
        end else begin
            credits_q <= credits_d;
            cnt_q     <= cnt_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            sv_q      <= sv_d;
            sid_q     <= sid_d;
            cd_mode_q <= cd_mode_d;
            cd_x_q    <= cd_x_d;
            cd_y_q    <= cd_y_d;
            cd_z_q    <= cd_z_d;
        end
    end

    // Result storage needs no reset: entries are only read while counted.
    always_ff @(posedge clk) begin
        if (cap) begin
            mem_q[wp_q] <= wdata;
        end
    end

    assign cd_mode = cd_mode_q;
    assign cd_x    = cd_x_q;
    assign cd_y    = cd_y_q;
    assign cd_z    = cd_z_q;

    // A capture into a full FIFO would mean the credit scheme is broken.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst) cap |-> (cnt_q != CW'(DEPTH))
    );

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: stand-in CORDIC pipeline plus a queue-based
// scoreboard of accepted operations checked every cycle.
module tb_cordic_arbiter;

    localparam int W     = 32;
    localparam int LAT   = 16;
    localparam int DEPTH = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic         req0_mode = 1'b0, req1_mode = 1'b0;
    logic [W-1:0] req0_x = '0, req0_y = '0, req0_z = '0;
    logic [W-1:0] req1_x = '0, req1_y = '0, req1_z = '0;
    logic         cd_mode;
    logic [W-1:0] cd_x, cd_y, cd_z;
    logic [W-1:0] cd_xo, cd_yo, cd_zo;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [W-1:0] rsp_x, rsp_y, rsp_z;
    logic         busy;

    always #5 clk = ~clk;

    cordic_arbiter #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_mode(req0_mode),
        .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_mode(req1_mode),
        .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z),
        .cd_mode(cd_mode), .cd_x(cd_x), .cd_y(cd_y), .cd_z(cd_z),
        .cd_xo(cd_xo), .cd_yo(cd_yo), .cd_zo(cd_zo),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
        .busy(busy)
    );

    // Stand-in for the CORDIC core: fixed function, LAT register stages.
    function automatic logic [3*W-1:0] cfun(input logic m, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input logic [W-1:0] z);
        return {x ^ 32'hA5A5_5A5A ^ {31'd0, m}, y + x, z - 32'd1};
    endfunction

    logic [3*W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= cfun(cd_mode, cd_x, cd_y, cd_z);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign {cd_xo, cd_yo, cd_zo} = pipe[LAT-1];

    typedef struct {
        logic           id;
        logic [3*W-1:0] res;
        int             avail;
    } ent_t;

    ent_t     q[$];
    logic     dlog[$];
    logic     lg = 1'b1;
    logic [3*W:0] ecd = '0;
    int total = 0, bad = 0;
    int cyc = 0;
    int dacc = 0, dpop = 0, drv = 0;
    int acc_cyc = 0, rv_cyc = -1;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic g, ok, e0, e1, ev;
        ent_t e;
        @(negedge clk);
        if (rst) begin
            chk("rst_rdy0", req0_ready, 0);
            chk("rst_rdy1", req1_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_x", rsp_x, 0);
            chk("rst_rsp_y", rsp_y, 0);
            chk("rst_rsp_z", rsp_z, 0);
            chk("rst_busy", busy, 0);
            chk("rst_cd", {cd_mode, cd_x, cd_y, cd_z}, 0);
            q.delete();
            lg  = 1'b1;
            ecd = '0;
        end else begin
`ifdef CORDIC_ARB_FIXED_PRIO_EN
            g = req1_valid && !req0_valid;
`else
            g = (req0_valid && req1_valid) ? !lg : req1_valid;
`endif
            ok = q.size() < DEPTH;
            e0 = ok && !g;
            e1 = ok && g;
            ev = (q.size() > 0) && (q[0].avail <= cyc);
            chk("rdy0", req0_ready, e0);
            chk("rdy1", req1_ready, e1);
            chk("rsp_valid", rsp_valid, ev);
            chk("busy", busy, q.size() > 0);
            chk("cd", {cd_mode, cd_x, cd_y, cd_z}, ecd);
            if (ev) begin
                chk("rsp_id", rsp_id, q[0].id);
                chk("rsp_xyz", {rsp_x, rsp_y, rsp_z}, q[0].res);
            end
            if (rsp_valid) begin
                drv++;
                if (rv_cyc < 0) rv_cyc = cyc;
                if (rsp_ready) dpop++;
            end
            if (req0_valid && req0_ready) begin
                dacc++; dlog.push_back(1'b0); acc_cyc = cyc;
            end
            if (req1_valid && req1_ready) begin
                dacc++; dlog.push_back(1'b1); acc_cyc = cyc;
            end
            if (ev && rsp_ready) void'(q.pop_front());
            if ((req0_valid && e0) || (req1_valid && e1)) begin
                e.id = g;
                ecd = g ? {req1_mode, req1_x, req1_y, req1_z}
                        : {req0_mode, req0_x, req0_y, req0_z};
                e.res = cfun(ecd[3*W], ecd[3*W-1:2*W], ecd[2*W-1:W], ecd[W-1:0]);
                e.avail = cyc + LAT + 2;
                q.push_back(e);
                lg = g;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic rand_ops();
        req0_mode = 1'($urandom); req1_mode = 1'($urandom);
        req0_x = $urandom; req0_y = $urandom; req0_z = $urandom;
        req1_x = $urandom; req1_y = $urandom; req1_z = $urandom;
    endtask

    task automatic clr();
        dacc = 0; dpop = 0; drv = 0; rv_cyc = -1; dlog.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        @(posedge clk); #1;
        step();
        rst = 1'b0;

        // single operation
        clr();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_mode = 1'b0;
        req0_x = 32'h4DBA76D4; req0_y = '0; req0_z = '0;
        step();
        req0_valid = 1'b0;
        repeat (30) step();
        chk("single_acc", dacc, 1);
        chk("single_rsp_cnt", drv, 1);
        chk("single_latency", rv_cyc - acc_cyc, LAT + 2);

        // contention
        do_reset();
        clr();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_acc", dlog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < dlog.size()) begin
`ifdef CORDIC_ARB_FIXED_PRIO_EN
                chk("cont_id", dlog[i], 0);
`else
                chk("cont_id", dlog[i], i % 2);
`endif
            end
        end
        repeat (LAT + 6) step();
        chk("cont_pops", dpop, 8);

        // backpressure
        clr();
        rsp_ready = 1'b0;
        req1_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_ops();
            step();
        end
        chk("bp_acc", dacc, DEPTH);
        chk("bp_rdy1_low", req1_ready, 0);
        req1_valid = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0; req1_valid = 1'b1;
        repeat (5) begin
            rand_ops();
            step();
        end
        chk("bp_one_pop", dpop, 1);
        chk("bp_one_more", dacc, DEPTH + 1);

        // simultaneous accept and pop at credits=1
        req1_valid = 1'b0; rsp_ready = 1'b1;
        step();
        req1_valid = 1'b1;
        rand_ops();
        step();
        chk("sim_rdy_hold", req1_ready, 1);
        req1_valid = 1'b0;
        repeat (DEPTH + LAT + 8) step();
        chk("bp_no_loss", dpop, dacc);
        chk("bp_idle", busy, 0);

        // random traffic
        clr();
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            rsp_ready  = ($urandom % 4) != 0;
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (DEPTH + LAT + 8) step();
        chk("rand_no_loss", dpop, dacc);

        // reset mid-operation
        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        repeat (5) begin
            rand_ops();
            step();
        end
        req0_valid = 1'b0;
        repeat (LAT + 4) step();
        req1_valid = 1'b1;
        repeat (10) begin
            rand_ops();
            step();
        end
        req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdy1", req1_ready, 0);
        step();
        rst = 1'b0;
        clr();
        rsp_ready = 1'b1;
        repeat (2 * LAT) step();
        chk("post_rst_stale", drv, 0);
        req1_valid = 1'b1;
        rand_ops();
        step();
        req1_valid = 1'b0;
        repeat (LAT + 6) step();
        chk("post_rst_cnt", drv, 1);
        chk("post_rst_latency", rv_cyc - acc_cyc, LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
